line_sum_frame_controller: RTL and testbench
============================================

// Module: line_sum_frame_controller
// PURPOSE
//  Sequences the line-sum accumulator over one frame: clears it, gates one line_sum per valid
//  line into it, counts NUM_OF_LINES lines, then captures the frame total and offers it
//  downstream on a valid/ready handshake. Sits between the per-line sum unit and the
//  statistics consumer; owns the accumulator's reset and input.
// PARAMETERS
//  LINE_SIZE      256   pixels per line (sizes LS_W)
//  NUM_OF_LINES   256   lines per frame (sizes line counter and ACC_W)
//  PIXEL_SIZE     8     bits per pixel
//  TIMEOUT_CYCLES 4096  max gap between lines in ACCUM (used only with LINE_TIMEOUT_EN)
//  Derived: LS_W = $clog2(LINE_SIZE)+2*PIXEL_SIZE (24); ACC_W = $clog2(NUM_OF_LINES)+LS_W (32)
// PORTS
//  CLK            in   1      clock; all logic on posedge
//  reset          in   1      synchronous, active-high
//  start          in   1      pulse: begin a frame (ignored unless IDLE)
//  line_valid     in   1      line_sum is valid this cycle (one pulse per line)
//  line_sum       in   LS_W   sum of squares for one line
//  acc_clr        out  1      synchronous clear to accumulator's reset
//  acc_line_sum   out  LS_W   accumulator input: line_sum when accepted, else 0
//  acc_sum        in   ACC_W  accumulator output (1-cycle latency after acc_line_sum)
//  frame_sum      out  ACC_W  captured frame total
//  frame_valid    out  1      frame_sum valid; held until frame_ready
//  frame_ready    in   1      consumer accepts frame_sum when frame_valid&frame_ready
//  busy           out  1      high in every state except IDLE
//  line_idx       out  $clog2(NUM_OF_LINES)  lines accepted so far this frame
//  timeout_err    out  1      sticky; exists only with LINE_TIMEOUT_EN
// BEHAVIOUR
//  Reset: state=IDLE; acc_clr=1 during reset cycle; all other outputs 0; frame_sum=0.
//  FSM: IDLE -start-> CLEAR (1 cycle, acc_clr=1, line_idx<=0) -> ACCUM.
//   ACCUM: line_valid -> acc_line_sum=line_sum (combinational), line_idx++; else acc_line_sum=0.
//    Accepting line NUM_OF_LINES-1 -> SETTLE; line_idx stays at NUM_OF_LINES-1 (no wrap).
//   SETTLE (1 cycle): acc_sum now includes last line; frame_sum<=acc_sum -> OUTPUT.
//   OUTPUT: frame_valid=1, frame_sum stable; frame_valid&frame_ready -> IDLE.
//  Latency: last line_valid at cycle N -> frame_valid rises at N+2.
//  line_valid outside ACCUM ignored: acc_line_sum=0, no count change.
//  start while busy ignored; start and frame_ready accepted same cycle in OUTPUT -> IDLE only.
//  acc_clr=1 only in reset and CLEAR; accumulator never free-runs on stale input.
//  Widths: acc_line_sum zero-extended by accumulator; no saturation, ACC_W sized for
//   NUM_OF_LINES*max(line_sum) so overflow impossible.
//  reset mid-frame: back to IDLE next cycle, partial frame discarded, frame_valid=0.
// CONFIGURATION
//  LINE_TIMEOUT_EN defined: cycle counter in ACCUM, cleared on each accepted line and on
//   entry; reaching TIMEOUT_CYCLES -> timeout_err<=1, state->IDLE, no frame_valid. Cleared by
//   reset or next start. Undefined: no counter, no timeout_err port, ACCUM waits forever.
// STRUCTURE
//  Shared package line_sum_pkg: PIXEL_SIZE/LINE_SIZE/NUM_OF_LINES, LS_W/ACC_W localparams,
//   typedef enum logic[2:0] {IDLE,CLEAR,ACCUM,SETTLE,OUTPUT} frame_state_t.
//  Single sub-module: line_counter (enable, clear, terminal-count flag); FSM stays top-level.
// TESTING (bench instantiates controller + real accumulator, NUM_OF_LINES=4)
//  1 start, line_sum 10,20,30,40 one per cycle -> frame_sum=100, frame_valid 2 cycles after 40.
//  2 lines with idle gaps, frame_ready low 5 cycles -> frame_valid/frame_sum=100 held; IDLE on ready.
//  3 line_valid pulses in IDLE and OUTPUT, extra start in ACCUM -> frame_sum unaffected, line_idx ok.
//  4 back-to-back frames (1s then 2s) -> 4 then 8; second frame starts from cleared acc.
//  5 reset after 2 lines -> IDLE, busy=0, frame_valid=0; next frame 5,5,5,5 -> 20.
//  6 LINE_TIMEOUT_EN, TIMEOUT_CYCLES=8: stop after line 2 -> timeout_err=1 at 8th idle cycle.

Source files
------------

// File: rtl/line_sum_frame_controller_pkg.sv
// Shared types and default sizing for the line-sum frame controller.
package line_sum_pkg;
  localparam int PIXEL_SIZE     = 8;
  localparam int LINE_SIZE      = 256;
  localparam int NUM_OF_LINES   = 256;
  localparam int TIMEOUT_CYCLES = 4096;
  localparam int LS_W  = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE;
  localparam int ACC_W = $clog2(NUM_OF_LINES) + LS_W;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    SETTLE,
    OUTPUT
  } frame_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/line_sum_frame_controller_if.sv
// Line input and frame output handshake bundle.
interface line_sum_frame_controller_if #(
  parameter int LS_W  = line_sum_pkg::LS_W,
  parameter int ACC_W = line_sum_pkg::ACC_W
);
  logic             line_valid;
  logic [LS_W-1:0]  line_sum;
  logic [ACC_W-1:0] frame_sum;
  logic             frame_valid;
  logic             frame_ready;

  modport master (
    output line_valid, line_sum, frame_ready,
    input  frame_sum, frame_valid
  );

  modport slave (
    input  line_valid, line_sum, frame_ready,
    output frame_sum, frame_valid
  );
endinterface

// File: rtl/line_sum_frame_controller_line_counter.sv
// Accepted-line counter; saturates at N-1 and flags terminal count.
module line_counter
  import line_sum_pkg::*;
#(
  parameter int N  = 256,
  parameter int CW = cnt_w(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);
  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == CW'(N - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !tc_o)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/line_sum_frame_controller.sv
// Frame sequencer for the line-sum accumulator.
// Optional LINE_TIMEOUT_EN adds an inter-line timeout and sticky timeout_err.
module line_sum_frame_controller #(
  parameter int LINE_SIZE      = line_sum_pkg::LINE_SIZE,
  parameter int NUM_OF_LINES   = line_sum_pkg::NUM_OF_LINES,
  parameter int PIXEL_SIZE     = line_sum_pkg::PIXEL_SIZE,
  parameter int TIMEOUT_CYCLES = line_sum_pkg::TIMEOUT_CYCLES,
  localparam int LS_W  = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE,
  localparam int ACC_W = $clog2(NUM_OF_LINES) + LS_W,
  localparam int LIW   = line_sum_pkg::cnt_w(NUM_OF_LINES)
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  line_sum_frame_controller_if.slave lbus,
  output logic                 acc_clr,
  output logic [LS_W-1:0]      acc_line_sum,
  input  logic [ACC_W-1:0]     acc_sum,
  output logic                 busy,
  output logic [LIW-1:0]       line_idx
`ifdef LINE_TIMEOUT_EN
  ,
  output logic                 timeout_err
`endif
);
  import line_sum_pkg::*;

  frame_state_t     state_q, state_d;
  logic [ACC_W-1:0] frame_sum_q, frame_sum_d;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic             tmo_hit;
  logic             line_ok;

  line_counter #(
    .N (NUM_OF_LINES),
    .CW(LIW)
  ) u_cnt (
    .clk  (CLK),
    .reset(reset),
    .clr_i(cnt_clr),
    .en_i (cnt_en),
    .cnt_o(line_idx),
    .tc_o (cnt_tc)
  );

  assign line_ok = lbus.line_valid && !reset;

`ifdef LINE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  assign tmo_hit     = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = err_q;

  always_comb begin
    tmo_d = tmo_q;
    err_d = err_q;
    if (state_q == IDLE && start)
      err_d = 1'b0;
    if (state_q == CLEAR || (state_q == ACCUM && line_ok))
      tmo_d = '0;
    else if (state_q == ACCUM) begin
      tmo_d = tmo_q + TW'(1);
      if (tmo_hit)
        err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    frame_sum_d  = frame_sum_q;
    acc_clr      = reset;
    acc_line_sum = '0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = CLEAR;
      end
      CLEAR: begin
        acc_clr = 1'b1;
        cnt_clr = 1'b1;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (line_ok) begin
          acc_line_sum = lbus.line_sum;
          cnt_en       = 1'b1;
          if (cnt_tc)
            state_d = SETTLE;
        end else if (tmo_hit)
          state_d = IDLE;
      end
      // accumulator output now includes the final line
      SETTLE: begin
        frame_sum_d = acc_sum;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        if (lbus.frame_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_sum_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign lbus.frame_valid = (state_q == OUTPUT);
  assign lbus.frame_sum   = frame_sum_q;
endmodule

// File: tb/tb_line_sum_frame_controller.sv
// Bench: controller plus behavioural accumulator, 4 lines per frame.
module tb_line_sum_frame_controller;
  localparam int NL = 4;
  localparam int LS = 24;
  localparam int AW = 26;

  logic          CLK = 1'b0;
  logic          reset;
  logic          start;
  logic          acc_clr;
  logic [LS-1:0] acc_line_sum;
  logic [AW-1:0] acc_sum;
  logic          busy;
  logic [1:0]    line_idx;
`ifdef LINE_TIMEOUT_EN
  logic          timeout_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  line_sum_frame_controller_if #(.LS_W(LS), .ACC_W(AW)) bus ();

  line_sum_frame_controller #(
    .LINE_SIZE     (256),
    .NUM_OF_LINES  (NL),
    .PIXEL_SIZE    (8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .start       (start),
    .lbus        (bus.slave),
    .acc_clr     (acc_clr),
    .acc_line_sum(acc_line_sum),
    .acc_sum     (acc_sum),
    .busy        (busy),
    .line_idx    (line_idx)
`ifdef LINE_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 CLK = ~CLK;

  // accumulator: clear on acc_clr, otherwise add the gated input
  always_ff @(posedge CLK) begin
    if (acc_clr)
      acc_sum <= '0;
    else
      acc_sum <= acc_sum + AW'(acc_line_sum);
  end

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic idle_inputs;
    bus.line_valid  = 1'b0;
    bus.line_sum    = LS'($urandom);
    bus.frame_ready = 1'b0;
    start           = 1'b0;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic send_line(input logic [LS-1:0] v);
    bus.line_valid = 1'b1;
    bus.line_sum   = v;
    tick();
    bus.line_valid = 1'b0;
    bus.line_sum   = LS'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.frame_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!bus.frame_valid)
      lat = -1;
  endtask

  task automatic accept;
    bus.frame_ready = 1'b1;
    tick();
    bus.frame_ready = 1'b0;
  endtask

  function automatic int exp_idx(input int k);
    return (k < NL) ? k : NL - 1;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    n_tests++;
    if (acc_clr !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_acc_clr got %b want 1", acc_clr);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({acc_clr, busy, bus.frame_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 000",
               {acc_clr, busy, bus.frame_valid});
    end
    n_tests++;
    if (bus.frame_sum !== '0 || line_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_vals sum %0d idx %0d want 0 0",
               bus.frame_sum, line_idx);
    end
`ifdef LINE_TIMEOUT_EN
    n_tests++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tmo got %b want 0", timeout_err);
    end
`endif
    tick();
  endtask

  task automatic test_basic;
    int vals[4] = '{10, 20, 30, 40};
    int lat;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (acc_clr !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_clear clr %b busy %b want 1 1", acc_clr, busy);
    end
    tick();
    n_tests++;
    if (acc_clr !== 1'b0 || acc_sum !== '0) begin
      n_fail++;
      $display("FAIL basic_accum clr %b acc %0d want 0 0", acc_clr, acc_sum);
    end
    for (int i = 0; i < 4; i++) begin
      bus.line_valid = 1'b1;
      bus.line_sum   = LS'(vals[i]);
      #1;
      n_tests++;
      if (acc_line_sum !== LS'(vals[i])) begin
        n_fail++;
        $display("FAIL basic_gate got %0d want %0d", acc_line_sum, vals[i]);
      end
      tick();
      n_tests++;
      if (line_idx !== 2'(exp_idx(i + 1))) begin
        n_fail++;
        $display("FAIL basic_idx got %0d want %0d", line_idx, exp_idx(i + 1));
      end
    end
    idle_inputs();
    wait_valid(lat);
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL basic_latency got %0d want 2", lat);
    end
    n_tests++;
    if (bus.frame_sum !== AW'(100)) begin
      n_fail++;
      $display("FAIL basic_sum got %0d want 100", bus.frame_sum);
    end
    accept();
    n_tests++;
    if (busy !== 1'b0 || bus.frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle busy %b valid %b want 0 0",
               busy, bus.frame_valid);
    end
  endtask

  task automatic test_ready_hold;
    int lat;
    do_start();
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < 1 + int'($urandom_range(2)); g++) begin
        #1;
        n_tests++;
        if (acc_line_sum !== '0) begin
          n_fail++;
          $display("FAIL hold_gap got %0d want 0", acc_line_sum);
        end
        tick();
      end
      send_line(LS'(10 * (i + 1)));
    end
    wait_valid(lat);
    n_tests++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL hold_latency got %0d want 2", lat);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++;
      if (bus.frame_valid !== 1'b1 || bus.frame_sum !== AW'(100)) begin
        n_fail++;
        $display("FAIL hold_stable valid %b sum %0d want 1 100",
                 bus.frame_valid, bus.frame_sum);
      end
    end
    accept();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_idle busy %b want 0", busy);
    end
  endtask

  task automatic test_ignored;
    int lat;
    logic [1:0] idx0;
    idx0 = line_idx;
    bus.line_valid = 1'b1;
    bus.line_sum   = LS'(999);
    #1;
    n_tests++;
    if (acc_line_sum !== '0) begin
      n_fail++;
      $display("FAIL ign_idle_gate got %0d want 0", acc_line_sum);
    end
    tick();
    idle_inputs();
    n_tests++;
    if (line_idx !== idx0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_idle idx %0d busy %b want %0d 0", line_idx, busy, idx0);
    end
    do_start();
    send_line(LS'(1));
    send_line(LS'(2));
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || line_idx !== 2'd2 || acc_sum !== AW'(3)) begin
      n_fail++;
      $display("FAIL ign_start busy %b idx %0d acc %0d want 1 2 3",
               busy, line_idx, acc_sum);
    end
    send_line(LS'(3));
    send_line(LS'(4));
    wait_valid(lat);
    bus.line_valid = 1'b1;
    bus.line_sum   = LS'(77);
    #1;
    n_tests++;
    if (acc_line_sum !== '0) begin
      n_fail++;
      $display("FAIL ign_out_gate got %0d want 0", acc_line_sum);
    end
    tick();
    idle_inputs();
    n_tests++;
    if (line_idx !== 2'd3 || bus.frame_sum !== AW'(10)) begin
      n_fail++;
      $display("FAIL ign_out idx %0d sum %0d want 3 10", line_idx, bus.frame_sum);
    end
    start           = 1'b1;
    bus.frame_ready = 1'b1;
    tick();
    idle_inputs();
    tick();
    n_tests++;
    if (busy !== 1'b0 || acc_clr !== 1'b0) begin
      n_fail++;
      $display("FAIL ign_start_ready busy %b clr %b want 0 0", busy, acc_clr);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    for (int f = 1; f <= 2; f++) begin
      do_start();
      n_tests++;
      if (acc_sum !== '0) begin
        n_fail++;
        $display("FAIL b2b_cleared got %0d want 0", acc_sum);
      end
      for (int i = 0; i < 4; i++)
        send_line(LS'(f));
      wait_valid(lat);
      n_tests++;
      if (lat !== 2 || bus.frame_sum !== AW'(4 * f)) begin
        n_fail++;
        $display("FAIL b2b_sum lat %0d sum %0d want 2 %0d",
                 lat, bus.frame_sum, 4 * f);
      end
      accept();
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    do_start();
    send_line(LS'(7));
    send_line(LS'(8));
    reset = 1'b1;
    #1;
    n_tests++;
    if (acc_clr !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_acc_clr got %b want 1", acc_clr);
    end
    tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({busy, bus.frame_valid} !== 2'b00 || line_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_idle busy %b valid %b idx %0d want 0 0 0",
               busy, bus.frame_valid, line_idx);
    end
    tick();
    do_start();
    for (int i = 0; i < 4; i++)
      send_line(LS'(5));
    wait_valid(lat);
    n_tests++;
    if (lat !== 2 || bus.frame_sum !== AW'(20)) begin
      n_fail++;
      $display("FAIL mid_next lat %0d sum %0d want 2 20", lat, bus.frame_sum);
    end
    accept();
  endtask

  task automatic test_random;
    int lat;
    longint exp;
    logic [LS-1:0] v;
    for (int f = 0; f < 20; f++) begin
      exp = 0;
      for (int g = 0; g < int'($urandom_range(2)); g++) begin
        bus.line_valid = $urandom_range(1);
        tick();
      end
      bus.line_valid = 1'b0;
      do_start();
      for (int i = 0; i < NL; i++) begin
        for (int g = 0; g < int'($urandom_range(2)); g++)
          tick();
        v = LS'($urandom);
        exp += longint'(v);
        send_line(v);
        n_tests++;
        if (line_idx !== 2'(exp_idx(i + 1))) begin
          n_fail++;
          $display("FAIL rnd_idx frame %0d got %0d want %0d",
                   f, line_idx, exp_idx(i + 1));
        end
      end
      wait_valid(lat);
      for (int g = 0; g < int'($urandom_range(3)); g++)
        tick();
      n_tests++;
      if (lat !== 2 || bus.frame_sum !== AW'(exp)) begin
        n_fail++;
        $display("FAIL rnd_sum frame %0d lat %0d sum %0d want 2 %0d",
                 f, lat, bus.frame_sum, exp);
      end
      accept();
    end
  endtask

`ifdef LINE_TIMEOUT_EN
  task automatic test_timeout;
    int lat;
    do_start();
    send_line(LS'(1));
    send_line(LS'(2));
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_tests++;
      if (timeout_err !== (i == 8) || busy !== (i < 8) ||
          bus.frame_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL tmo_idle%0d err %b busy %b valid %b", i,
                 timeout_err, busy, bus.frame_valid);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_tests++;
    if (timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_clear got %b want 0", timeout_err);
    end
    tick();
    for (int i = 0; i < 4; i++)
      send_line(LS'(3));
    wait_valid(lat);
    n_tests++;
    if (lat !== 2 || bus.frame_sum !== AW'(12)) begin
      n_fail++;
      $display("FAIL tmo_recover lat %0d sum %0d want 2 12", lat, bus.frame_sum);
    end
    accept();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_ready_hold();
    test_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef LINE_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
